demux_1_4: RTL and testbench

Registered 1-to-4 demultiplexer: the distribution side of the team's 4:1 multiplexer. It accepts one W-bit word per cycle on a valid/ready input and routes it to one of four output channels, each backed by a one-entry holding slot with its own valid/ready handshake. Channel selection is explicit through a 2-bit select. Optionally, a round-robin pointer selects the channel instead. The block sits between a single producer and four independent consumers in the lab datapath.

---
 rtl/demux_pkg.sv | 25 ++
 rtl/demux_slot.sv | 42 ++++
 rtl/demux_1_4.sv | 79 +++++++
 tb/tb_demux_1_4.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 registered demultiplexer.
// Channel count, select width, default word width and channel-index helpers.
// Imported by demux_slot and demux_1_4.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int DEF_W = 4;

  typedef logic [SEL_W-1:0] ch_idx_t;
  typedef logic [NCH-1:0]   ch_mask_t;

  // Round-robin successor; the SEL_W-bit add wraps 3 -> 0 naturally.
  function automatic ch_idx_t next_ch(input ch_idx_t c);
    return c + ch_idx_t'(1);
  endfunction

  function automatic ch_mask_t ch_onehot(input ch_idx_t c);
    ch_mask_t m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot: W-bit data register plus full flag.
// Latency: fill visible after the edge. Backpressure: a fill and drain in the same cycle keeps it full.
// Data is only written on fill, so it stays stable under backpressure and after drain.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fill,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] dat
);

  logic         full_q;
  logic [W-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (fill) begin
      full_q <= 1'b1;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat_q <= '0;
    end else if (fill) begin
      dat_q <= d;
    end
  end

  assign vld = full_q;
  assign dat = dat_q;

endmodule

// File: rtl/demux_1_4.sv
// Registered 1-to-4 demux with per-channel one-entry slots; round-robin select under DEMUX_AUTO_EN.
// Latency: word accepted at edge n is valid on its channel after edge n; one word per cycle sustained.
// Backpressure: i_ready = slot empty or being drained this cycle; no path from i_valid to i_ready.
module demux_1_4
  import demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [1:0]   s,
  input  logic         auto,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   y_valid,
  input  logic [3:0]   y_ready,
  output logic [3:0]   occ,
  output logic [1:0]   ptr
);

  ch_idx_t        sel;
  ch_mask_t       full;
  ch_mask_t       drain;
  ch_mask_t       fill;
  logic           accept;
  logic [W-1:0]   slot_dat [NCH];

`ifdef DEMUX_AUTO_EN
  ch_idx_t ptr_q;

  // Pointer advances only on words actually taken in auto mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept && auto) begin
      ptr_q <= next_ch(ptr_q);
    end
  end

  assign sel = auto ? ptr_q : ch_idx_t'(s);
  assign ptr = ptr_q;
`else
  logic unused_auto;

  assign unused_auto = auto;
  assign sel         = ch_idx_t'(s);
  assign ptr         = '0;
`endif

  assign drain   = full & y_ready;
  assign i_ready = ~full[sel] | y_ready[sel];
  assign accept  = i_valid & i_ready;
  assign fill    = accept ? ch_onehot(sel) : '0;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .fill  (fill[k]),
      .drain (drain[k]),
      .d     (i),
      .vld   (full[k]),
      .dat   (slot_dat[k])
    );
  end

  assign y0      = slot_dat[0];
  assign y1      = slot_dat[1];
  assign y2      = slot_dat[2];
  assign y3      = slot_dat[3];
  assign y_valid = full;
  assign occ     = full;

endmodule

// File: tb/tb_demux_1_4.sv
// Self-checking bench for demux_1_4: directed scenarios plus randomized traffic
// against a slot/pointer reference model; auto-mode scenarios build only with DEMUX_AUTO_EN.
module tb_demux_1_4;

  localparam int W = 4;
`ifdef DEMUX_AUTO_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] i;
  logic         i_valid;
  logic         i_ready;
  logic [1:0]   s;
  logic         auto;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   y_valid;
  logic [3:0]   y_ready;
  logic [3:0]   occ;
  logic [1:0]   ptr;

  int checks   = 0;
  int failures = 0;

  bit           m_full [4];
  logic [W-1:0] m_dat  [4];
  int           m_ptr;

  always #5 clk = ~clk;

  demux_1_4 #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .s       (s),
    .auto    (auto),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .occ     (occ),
    .ptr     (ptr)
  );

  function automatic logic [W-1:0] y_of(input int k);
    case (k)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  function automatic int m_sel();
    return (AUTO_EN && auto) ? m_ptr : int'(s);
  endfunction

  function automatic logic m_ready();
    int k;
    k = m_sel();
    return (!m_full[k] || y_ready[k]) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [3:0] m_yvalid();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  // Reference behaviour at a rising edge, from the inputs held across it.
  task automatic model_edge();
    int k;
    bit acc;
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) begin
        m_full[j] = 1'b0;
        m_dat[j]  = '0;
      end
      m_ptr = 0;
    end else begin
      k   = m_sel();
      acc = i_valid && m_ready();
      for (int j = 0; j < 4; j++)
        if (m_full[j] && y_ready[j]) m_full[j] = 1'b0;
      if (acc) begin
        m_full[k] = 1'b1;
        m_dat[k]  = i;
        if (AUTO_EN && auto) m_ptr = (m_ptr + 1) % 4;
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                       input logic [1:0] sv, input logic a, input logic [3:0] yr);
    @(negedge clk);
    rst_n   = r;
    i_valid = v;
    i       = d;
    s       = sv;
    auto    = a;
    y_ready = yr;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (y_valid !== 4'b0000) begin
      failures++; $display("FAIL reset_y_valid got=%b exp=0000", y_valid);
    end
    checks++;
    if (occ !== 4'b0000) begin
      failures++; $display("FAIL reset_occ got=%b exp=0000", occ);
    end
    checks++;
    if ({y3, y2, y1, y0} !== '0) begin
      failures++; $display("FAIL reset_y_data got=%h_%h_%h_%h exp=0", y3, y2, y1, y0);
    end
    checks++;
    if (ptr !== 2'd0) begin
      failures++; $display("FAIL reset_ptr got=%0d exp=0", ptr);
    end
    checks++;
    if (i_ready !== 1'b1) begin
      failures++; $display("FAIL reset_i_ready got=%b exp=1", i_ready);
    end
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b1, 4'hA, 2'd2, 1'b0, 4'b0000);
    #1;
    checks++;
    if (i_ready !== 1'b1) begin
      failures++; $display("FAIL fill_ready_before got=%b exp=1", i_ready);
    end
    cycle();
    checks++;
    if (y2 !== 4'hA || y_valid !== 4'b0100) begin
      failures++; $display("FAIL fill_slot2 got y2=%h vld=%b exp y2=a vld=0100", y2, y_valid);
    end
    drive(1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'b0000);
    #1;
    checks++;
    if (i_ready !== 1'b0) begin
      failures++; $display("FAIL fill_ready_full got=%b exp=0", i_ready);
    end
  endtask

  task automatic test_drain_fill_same();
    drive(1'b1, 1'b1, 4'h5, 2'd2, 1'b0, 4'b0100);
    #1;
    checks++;
    if (i_ready !== 1'b1) begin
      failures++; $display("FAIL dfs_ready got=%b exp=1", i_ready);
    end
    cycle();
    checks++;
    if (y2 !== 4'h5 || y_valid[2] !== 1'b1) begin
      failures++; $display("FAIL dfs_slot2 got y2=%h vld2=%b exp y2=5 vld2=1", y2, y_valid[2]);
    end
    drive(1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (y2 !== 4'h5 || y_valid !== 4'b0100) begin
      failures++; $display("FAIL dfs_hold got y2=%h vld=%b exp y2=5 vld=0100", y2, y_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 4'b0000);
    cycle();
    for (int w = 1; w <= 3; w++) begin
      drive(1'b1, 1'b1, W'(w), 2'd1, 1'b0, 4'b0000);
      #1;
      checks++;
      if (i_ready !== (w == 1)) begin
        failures++; $display("FAIL bp_ready word=%0d got=%b exp=%b", w, i_ready, (w == 1));
      end
      cycle();
      checks++;
      if (y1 !== 4'h1 || y_valid !== 4'b0010) begin
        failures++; $display("FAIL bp_hold word=%0d got y1=%h vld=%b exp y1=1 vld=0010", w, y1, y_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 4'h7, 2'd0, 1'b0, 4'b0000); cycle();
    drive(1'b1, 1'b1, 4'h8, 2'd3, 1'b0, 4'b0000); cycle();
    checks++;
    if (y_valid !== 4'b1011) begin
      failures++; $display("FAIL rmid_pre got=%b exp=1011", y_valid);
    end
    drive(1'b0, 1'b1, 4'hF, 2'd2, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (y_valid !== 4'b0000 || occ !== 4'b0000 || ptr !== 2'd0) begin
      failures++; $display("FAIL rmid_state got vld=%b occ=%b ptr=%0d exp 0000/0000/0", y_valid, occ, ptr);
    end
    checks++;
    if ({y3, y2, y1, y0} !== '0 || i_ready !== 1'b1) begin
      failures++; $display("FAIL rmid_data got y=%h_%h_%h_%h rdy=%b exp 0 rdy=1", y3, y2, y1, y0, i_ready);
    end
  endtask

`ifdef DEMUX_AUTO_EN
  task automatic test_auto_rr();
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 4'b0000);
    cycle();
    for (int w = 0; w < 8; w++) begin
      drive(1'b1, 1'b1, W'(w), 2'(3 - (w % 4)), 1'b1, 4'b1111);
      #1;
      checks++;
      if (i_ready !== 1'b1) begin
        failures++; $display("FAIL rr_ready word=%0d got=%b exp=1", w, i_ready);
      end
      cycle();
      checks++;
      if (y_valid !== 4'(1 << (w % 4)) || y_of(w % 4) !== W'(w)) begin
        failures++; $display("FAIL rr_route word=%0d got vld=%b y=%h exp ch=%0d", w, y_valid, y_of(w % 4), w % 4);
      end
    end
    checks++;
    if (ptr !== 2'd0) begin
      failures++; $display("FAIL rr_ptr_wrap got=%0d exp=0", ptr);
    end
  endtask

  task automatic test_auto_stall_wrap();
    drive(1'b0, 1'b0, '0, 2'd0, 1'b0, 4'b0000);
    cycle();
    for (int w = 0; w < 3; w++) begin
      drive(1'b1, 1'b1, W'(w + 1), 2'd0, 1'b1, 4'b0000);
      cycle();
    end
    drive(1'b1, 1'b1, 4'hC, 2'd3, 1'b0, 4'b0000);
    cycle();
    checks++;
    if (ptr !== 2'd3 || y_valid !== 4'b1111) begin
      failures++; $display("FAIL stall_setup got ptr=%0d vld=%b exp ptr=3 vld=1111", ptr, y_valid);
    end
    drive(1'b1, 1'b1, 4'hD, 2'd0, 1'b1, 4'b0000);
    #1;
    checks++;
    if (i_ready !== 1'b0) begin
      failures++; $display("FAIL stall_ready got=%b exp=0", i_ready);
    end
    cycle();
    checks++;
    if (ptr !== 2'd3 || y3 !== 4'hC) begin
      failures++; $display("FAIL stall_hold got ptr=%0d y3=%h exp ptr=3 y3=c", ptr, y3);
    end
    drive(1'b1, 1'b1, 4'hD, 2'd0, 1'b1, 4'b1000);
    #1;
    checks++;
    if (i_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release got=%b exp=1", i_ready);
    end
    cycle();
    checks++;
    if (ptr !== 2'd0 || y3 !== 4'hD || y_valid[3] !== 1'b1) begin
      failures++; $display("FAIL stall_wrap got ptr=%0d y3=%h vld3=%b exp ptr=0 y3=d vld3=1", ptr, y3, y_valid[3]);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), 1'($urandom), W'($urandom), 2'($urandom),
            1'($urandom), 4'($urandom));
      #1;
      checks++;
      if (i_ready !== m_ready()) begin
        failures++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, i_ready, m_ready());
      end
      cycle();
      checks++;
      if (y_valid !== m_yvalid() || occ !== m_yvalid() || ptr !== 2'(m_ptr)) begin
        failures++; $display("FAIL rnd_state n=%0d got vld=%b occ=%b ptr=%0d exp vld=%b ptr=%0d",
                             n, y_valid, occ, ptr, m_yvalid(), m_ptr);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (y_of(k) !== m_dat[k]) begin
          failures++; $display("FAIL rnd_data n=%0d ch=%0d got=%h exp=%h", n, k, y_of(k), m_dat[k]);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i       = '0;
    i_valid = 1'b0;
    s       = 2'd0;
    auto    = 1'b0;
    y_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_dat[k]  = '0;
    end
    m_ptr = 0;

    test_reset();
    test_fill();
    test_drain_fill_same();
    test_backpressure();
    test_reset_mid();
`ifdef DEMUX_AUTO_EN
    test_auto_rr();
    test_auto_stall_wrap();
`endif
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
